// File: rtl/gf_red_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gf_red_if : operand/result bundle for the gf_red reduction unit       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface gf_red_if #(
   parameter int DATA_WIDTH = 8
);
   logic                            op_enable;
   logic [$clog2(DATA_WIDTH):0]     polyn_grade;
   logic [DATA_WIDTH:0]             polyn_red_in;
   logic [2*DATA_WIDTH-1:0]         reduc_in;
   logic [DATA_WIDTH-1:0]           out;
   logic                            op_finish;

   modport master (
      output op_enable, polyn_grade, polyn_red_in, reduc_in,
      input  out, op_finish
   );

   modport slave (
      input  op_enable, polyn_grade, polyn_red_in, reduc_in,
      output out, op_finish
   );
endinterface
`default_nettype wire

// File: rtl/gf_red.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gf_red : sequential GF(2)[x] reduction, one dividend bit per clock     |
// | Option macro: GF_RED_EARLY_EXIT_EN (exit once the high part is zero)   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module gf_red #(
   parameter int DATA_WIDTH = 8
) (
   input  wire logic clk,
   input  wire logic rst,
   gf_red_if.slave   bus
);
   localparam int c_DW2 = 2 * DATA_WIDTH;
   localparam int c_IW  = $clog2(c_DW2);
   localparam int c_GW  = $clog2(DATA_WIDTH) + 1;

   localparam logic [1:0] c_S_IDLE = 2'd0;
   localparam logic [1:0] c_S_RUN  = 2'd1;
   localparam logic [1:0] c_S_WRAP = 2'd2;
   localparam logic [1:0] c_S_DONE = 2'd3;

   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;
   logic [c_DW2-1:0]      r_acc;
   logic [DATA_WIDTH:0]   r_poly;
   logic [c_GW-1:0]       r_g;
   logic [c_IW-1:0]       r_idx;
   logic [DATA_WIDTH-1:0] r_out;
   logic                  r_finish;

   logic [c_GW-1:0]       w_g_eff;
   logic [c_IW-1:0]       w_g_ext;
   logic [c_IW-1:0]       w_shamt;
   logic [c_DW2-1:0]      w_poly_ext;
   logic [c_DW2-1:0]      w_acc_nxt;
   logic                  w_last;
   logic                  w_exit;
   logic [DATA_WIDTH-1:0] w_mask;
   logic                  w_load;
   logic                  w_step;
   logic                  w_commit;

   assign w_g_eff    = (bus.polyn_grade > c_GW'(DATA_WIDTH)) ? c_GW'(DATA_WIDTH) : bus.polyn_grade;
   assign w_g_ext    = c_IW'(r_g);
   assign w_shamt    = r_idx - w_g_ext;
   assign w_poly_ext = {{(c_DW2-DATA_WIDTH-1){1'b0}}, r_poly};
   assign w_acc_nxt  = r_acc[r_idx] ? (r_acc ^ (w_poly_ext << w_shamt)) : r_acc;
   assign w_last     = (r_idx == w_g_ext);
   assign w_mask     = ~({DATA_WIDTH{1'b1}} << r_g);

`ifdef GF_RED_EARLY_EXIT_EN
   // Nothing at or above x^g left to cancel: the remainder is already final.
   assign w_exit = w_last || ((r_acc >> w_g_ext) == '0);
`else
   assign w_exit = w_last;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Grade 0 skips RUN; WRAP then commits acc masked to nothing, i.e. zero.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_S_IDLE: if (bus.op_enable) w_state_nxt = (w_g_eff == '0) ? c_S_WRAP : c_S_RUN;
         c_S_RUN:  if (!bus.op_enable) w_state_nxt = c_S_IDLE;
                   else if (w_exit)    w_state_nxt = c_S_WRAP;
         c_S_WRAP: w_state_nxt = bus.op_enable ? c_S_DONE : c_S_IDLE;
         c_S_DONE: if (!bus.op_enable) w_state_nxt = c_S_IDLE;
         default:  w_state_nxt = c_S_IDLE;
      endcase
   end

   always_comb begin
      w_load   = 1'b0;
      w_step   = 1'b0;
      w_commit = 1'b0;
      case (r_state)
         c_S_IDLE: w_load   = bus.op_enable;
         c_S_RUN:  w_step   = bus.op_enable;
         c_S_WRAP: w_commit = bus.op_enable;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc    <= '0;
         r_poly   <= '0;
         r_g      <= '0;
         r_idx    <= '0;
         r_out    <= '0;
         r_finish <= 1'b0;
      end else begin
         r_finish <= (w_state_nxt == c_S_DONE);
         if (w_load) begin
            r_acc  <= bus.reduc_in;
            r_poly <= bus.polyn_red_in;
            r_g    <= w_g_eff;
            r_idx  <= c_IW'(c_DW2 - 1);
         end
         if (w_step) begin
            r_acc <= w_acc_nxt;
            r_idx <= r_idx - c_IW'(1);
         end
         if (w_commit) begin
            r_out <= r_acc[DATA_WIDTH-1:0] & w_mask;
         end
      end
   end

   assign bus.out       = r_out;
   assign bus.op_finish = r_finish;
endmodule
`default_nettype wire

// File: tb/tb_gf_red.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gf_red : directed + random scoreboard bench for gf_red             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_gf_red;
   localparam int W = 8;

   typedef struct {
      logic [W-1:0] out;
      int           lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   logic [W-1:0] last_out;
   exp_t sb[$];

   always #5 clk = ~clk;

   gf_red_if #(.DATA_WIDTH(W)) bus ();
   gf_red #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input int g, input logic [W:0] p, input logic [2*W-1:0] r);
      logic [2*W-1:0] a;
      logic [2*W-1:0] pe;
      int             ge;
      ge = (g > W) ? W : g;
      if (ge == 0) return '0;
      a  = r;
      pe = {{(W-1){1'b0}}, p};
      for (int i = 2*W-1; i >= ge; i--)
         if (a[i]) a ^= pe << (i - ge);
      for (int i = ge; i < W; i++) a[i] = 1'b0;
      return a[W-1:0];
   endfunction

   // Cycles from the sampling edge to op_finish; -1 means not checked.
   function automatic int exp_lat(input int g, input logic [W:0] p, input logic [2*W-1:0] r);
      int ge;
      ge = (g > W) ? W : g;
      if (ge == 0) return -1;
`ifdef GF_RED_EARLY_EXIT_EN
      begin
         logic [2*W-1:0] a;
         logic [2*W-1:0] pe;
         a  = r;
         pe = {{(W-1){1'b0}}, p};
         for (int k = 1, idx = 2*W-1; k <= 2*W; k++, idx--) begin
            if ((a >> ge) == '0) return k + 1;
            if (a[idx]) a ^= pe << (idx - ge);
            if (idx == ge) return k + 1;
         end
         return -1;
      end
`else
      return 2*W - ge + 1;
`endif
   endfunction

   task automatic run_op(input string tag, input int g, input logic [W:0] p,
                         input logic [2*W-1:0] r, input logic [W-1:0] exp_out);
      exp_t e;
      int   cyc;
      e.out = exp_out;
      e.lat = exp_lat(g, p, r);
      sb.push_back(e);
      @(negedge clk);
      bus.polyn_grade  = 4'(g);
      bus.polyn_red_in = p;
      bus.reduc_in     = r;
      bus.op_enable    = 1'b1;
      @(posedge clk); #1;
      cyc = 0;
      while (!bus.op_finish && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      e = sb.pop_front();
      check({tag, "_fin"}, 32'(bus.op_finish), 32'd1);
      check({tag, "_out"}, 32'(bus.out), 32'(e.out));
      if (e.lat >= 0) check({tag, "_lat"}, cyc, e.lat);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_hold"}, 32'(bus.op_finish), 32'd1);
      @(negedge clk);
      bus.op_enable = 1'b0;
      @(posedge clk); #1;
      check({tag, "_drop"}, 32'(bus.op_finish), 32'd0);
      check({tag, "_keep"}, 32'(bus.out), 32'(e.out));
      last_out = e.out;
   endtask

   initial begin
      int          seen;
      int          g;
      logic [W:0]  p;
      logic [2*W-1:0] r;

      rst = 1'b1;
      bus.op_enable    = 1'b0;
      bus.polyn_grade  = '0;
      bus.polyn_red_in = '0;
      bus.reduc_in     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out", 32'(bus.out), 32'd0);
      check("rst_fin", 32'(bus.op_finish), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("g4", 4, 9'd19, 16'd90, 8'd5);
      run_op("g3", 3, 9'd11, 16'd27, 8'd6);
      run_op("g2", 2, 9'd6, 16'd7, 8'd1);
      run_op("zero_div", 4, 9'd19, 16'd0, 8'd0);
      run_op("g0", 0, 9'd19, 16'd90, 8'd0);
      run_op("small", 4, 9'd19, 16'd5, 8'd5);
      run_op("clamp", 12, 9'h11B, 16'hBEEF, model(12, 9'h11B, 16'hBEEF));
      run_op("g8", 8, 9'h11B, 16'hFFFF, model(8, 9'h11B, 16'hFFFF));

      // Abort mid-RUN: finish must never rise and out must hold.
      run_op("pre_abort", 3, 9'd11, 16'd27, 8'd6);
      @(negedge clk);
      bus.polyn_grade = 4'd4; bus.polyn_red_in = 9'd19; bus.reduc_in = 16'd90;
      bus.op_enable = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      bus.op_enable = 1'b0;
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.op_finish) seen++;
      end
      check("abort_fin", seen, 0);
      check("abort_out", 32'(bus.out), 32'(last_out));
      run_op("restart", 4, 9'd19, 16'd90, 8'd5);

      for (int i = 0; i < 6; i++) begin
         g = int'($urandom_range(1, 9));
         p = 9'($urandom);
         r = 16'($urandom);
         run_op($sformatf("rand%0d", i), g, p, r, model(g, p, r));
      end

      // Asynchronous reset in the middle of an operation.
      run_op("pre_rst", 4, 9'd19, 16'd90, 8'd5);
      @(negedge clk);
      bus.polyn_grade = 4'd3; bus.polyn_red_in = 9'd11; bus.reduc_in = 16'd27;
      bus.op_enable = 1'b1;
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_out", 32'(bus.out), 32'd0);
      check("arst_fin", 32'(bus.op_finish), 32'd0);
      bus.op_enable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle_fin", 32'(bus.op_finish), 32'd0);
      check("idle_out", 32'(bus.out), 32'd0);
      run_op("post_rst", 3, 9'd11, 16'd27, 8'd6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
